instr_encoder_loader: RTL

Builds 16-bit WISC instruction words from field-level inputs and writes them in order into instruction memory. The control decoder in the fetch/decode stage consumes those words, so opcode classes and field layouts here mirror its opcode map exactly. The block sits on the test/boot path ahead of instruction memory and streams a program in at one instruction per cycle. It range-checks immediates against each opcode's extension rule, flags illegal encodings, and stops after HALT or when memory is full.

---
 rtl/instr_encoder_loader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//   Builds 16-bit WISC instruction words from field-level inputs and streams
//   them, one per cycle, into instruction memory starting at address 0.
//   Immediates are range-checked against each opcode's extension rule.
//   Illegal bundles are swallowed and raise a sticky error. Loading stops after
//   HALT is written or once DEPTH words have been written.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start                     pulse: clear address/done/full and (re)enter LOAD
//   in_valid / in_ready       field-bundle handshake (accept = valid && ready)
//   op, rs, rt, rd, func, imm instruction fields (imm is two's complement)
//   wr_en, wr_addr, wr_data   instruction-memory write port (1-cycle latency)
//   err, err_addr             sticky illegal-bundle flag and the address
//                             current when the first error occurred
//   done, full                HALT written / DEPTH words written
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic [2:0]        rs,
    input  logic [2:0]        rt,
    input  logic [2:0]        rd,
    input  logic [1:0]        func,
    input  logic [15:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              done,
    output logic              full
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FMT_Z   = 3'd0,
        FMT_I1  = 3'd1,
        FMT_I2  = 3'd2,
        FMT_R   = 3'd3,
        FMT_J   = 3'd4,
        FMT_BAD = 3'd5
    } fmt_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [4:0]        OP_HALT   = 5'b00000;

    // Instruction format for each opcode; mirrors the decoder's opcode map.
    function automatic fmt_t op_format(input logic [4:0] o);
        fmt_t f;
        case (o)
            5'b00000, 5'b00001, 5'b00010, 5'b00011: f = FMT_Z;
            5'b00100, 5'b00110:                     f = FMT_J;
            5'b00101, 5'b00111,
            5'b01100, 5'b01101, 5'b01110, 5'b01111,
            5'b10010, 5'b11000:                     f = FMT_I2;
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b10000, 5'b10001, 5'b10011,
            5'b10100, 5'b10101, 5'b10110, 5'b10111: f = FMT_I1;
            5'b11001, 5'b11010, 5'b11011,
            5'b11100, 5'b11101, 5'b11110, 5'b11111: f = FMT_R;
            default:                                f = FMT_BAD;
        endcase
        return f;
    endfunction

    // True when imm fits the field of opcode o (zero- or sign-extended).
    function automatic logic imm_in_range(input logic [4:0] o, input logic [15:0] i);
        logic signed [15:0] s;
        logic               ok;
        s = i;
        case (o)
            // zero-extended 5-bit logical immediates
            5'b01010, 5'b01011:
                ok = (i <= 16'd31);
            // shift/rotate amounts only use 4 bits
            5'b10100, 5'b10101, 5'b10110, 5'b10111:
                ok = (i <= 16'd15);
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
                ok = (s >= -16'sd16) && (s <= 16'sd15);
            // SLBI shifts in an unsigned byte
            5'b10010:
                ok = (i <= 16'd255);
            5'b00101, 5'b00111, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000:
                ok = (s >= -16'sd128) && (s <= 16'sd127);
            5'b00100, 5'b00110:
                ok = (s >= -16'sd1024) && (s <= 16'sd1023);
            // R and zero-operand formats carry no immediate
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b11001, 5'b11010, 5'b11011,
            5'b11100, 5'b11101, 5'b11110, 5'b11111:
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pack the fields into a 16-bit word according to the format.
    function automatic logic [15:0] encode_word(
        input fmt_t        f,
        input logic [4:0]  o,
        input logic [2:0]  a,
        input logic [2:0]  b,
        input logic [2:0]  c,
        input logic [1:0]  fn,
        input logic [15:0] i
    );
        logic [15:0] w;
        case (f)
            FMT_I1:  w = {o, a, c, i[4:0]};
            FMT_I2:  w = {o, a, i[7:0]};
            FMT_R:   w = {o, a, b, c, fn};
            FMT_J:   w = {o, i[10:0]};
            FMT_Z:   w = {o, 11'd0};
            default: w = 16'd0;
        endcase
        return w;
    endfunction

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;      // address the next legal bundle uses
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [15:0]       wr_data_q,  wr_data_d;
    logic              err_q,      err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              done_q,     done_d;
    logic              full_q,     full_d;

    logic              ready_s;
    logic              accept_s;
    logic              legal_s;
    logic              bad_s;
    fmt_t              fmt_s;

    assign ready_s  = (state_q == ST_LOAD) && !start;
    assign in_ready = ready_s;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign done     = done_q;
    assign full     = full_q;

    // Classify the incoming bundle as a legal write or an illegal one.
    always_comb begin
        fmt_s    = op_format(op);
        accept_s = in_valid && ready_s;
        legal_s  = accept_s && (fmt_s != FMT_BAD) && imm_in_range(op, imm);
        bad_s    = accept_s && !legal_s;
    end

    // Next-state, address counter and output register inputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en_d    = legal_s;
        // wr_addr shows the write address during a write, else the next address
        wr_addr_d  = start ? {ADDR_W{1'b0}} : cnt_q;
        wr_data_d  = legal_s ? encode_word(fmt_s, op, rs, rt, rd, func, imm) : wr_data_q;
        err_d      = err_q | bad_s;
        err_addr_d = (bad_s && !err_q) ? cnt_q : err_addr_q;
        done_d     = done_q;
        full_d     = full_q;

        if (start) begin
            cnt_d  = {ADDR_W{1'b0}};
            done_d = 1'b0;
            full_d = 1'b0;
        end else if (legal_s) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (op == OP_HALT) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
            if (cnt_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                full_d = full_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        // The state leaves LOAD in the accept cycle so that in_ready drops
        // before a following bundle could be taken.
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
                else       state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (legal_s && (op == OP_HALT))     state_d = ST_DONE;
                else if (legal_s && (cnt_q == LAST_ADDR)) state_d = ST_FULL;
                else                                state_d = ST_LOAD;
            end
            ST_DONE, ST_FULL: begin
                if (start) state_d = ST_LOAD;
                else       state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {ADDR_W{1'b0}};
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= 16'd0;
            err_q      <= 1'b0;
            err_addr_q <= {ADDR_W{1'b0}};
            done_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            done_q     <= done_d;
            full_q     <= full_d;
        end
    end

endmodule
